// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt controller request stage:
// request width, acknowledge FSM encoding and the spurious vector level.
package pic_pkg;

  localparam int N_IRQ = 8;
  localparam int LVL_W = 3;

  // Encoding doubles as the number_of_ack count seen by the control stage.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK1 = 2'd1,
    ST_ACK2 = 2'd2
  } ack_state_e;

  localparam logic [LVL_W-1:0] SPURIOUS_LVL = 3'd7;

  function automatic logic [N_IRQ-1:0] lvl_mask(input logic [LVL_W-1:0] lvl);
    logic [N_IRQ-1:0] m;
    m      = '0;
    m[lvl] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/priority_resolver.sv
// Fixed-priority encoder: reports the lowest-index set bit (bit 0 wins)
// and whether any bit is set at all.
module priority_resolver
  import pic_pkg::*;
(
  input  logic [N_IRQ-1:0] req,
  output logic [LVL_W-1:0] lvl,
  output logic             valid
);

  always_comb begin
    lvl   = SPURIOUS_LVL;
    valid = |req;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) lvl = LVL_W'(i);
    end
  end

endmodule

// File: rtl/interrupt_priority_unit.sv
// Request side of the interrupt controller: IRR latching, masking, fixed
// priority against the ISR, int_out generation and the two-pulse INTA sequence.
module interrupt_priority_unit
  import pic_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] ir,
  input  logic             ltim,
  input  logic             aeoi,
  input  logic [N_IRQ-1:0] imr,
  input  logic             eoi_nonspec,
  input  logic             eoi_spec,
  input  logic [LVL_W-1:0] eoi_level,
  input  logic             inta_n,
  output logic             int_out,
  output logic [N_IRQ-1:0] irr,
  output logic [N_IRQ-1:0] isr,
  output logic [1:0]       number_of_ack
);

  // INTA handshake: the CPU answers int_out with two low pulses on inta_n.
  // The first falling edge freezes the winning level and moves it from IRR
  // to ISR; the second falling edge only advances the count; the rising edge
  // that ends the second pulse closes the cycle (and performs AEOI).
  logic [N_IRQ-1:0] ir_d;
  logic             inta_d;
  logic [N_IRQ-1:0] ir_rise;
  logic             inta_fall;
  logic             inta_rise;

  assign ir_rise   = ir & ~ir_d;
  assign inta_fall = inta_d & ~inta_n;
  assign inta_rise = ~inta_d & inta_n;

  logic [N_IRQ-1:0] pend;
  logic [LVL_W-1:0] req_lvl;
  logic             pend_any;
  logic [LVL_W-1:0] svc_lvl;
  logic             isr_any;
  logic             req_valid;

  assign pend = irr & ~imr;

  priority_resolver u_req_res (
    .req   (pend),
    .lvl   (req_lvl),
    .valid (pend_any)
  );

  priority_resolver u_svc_res (
    .req   (isr),
    .lvl   (svc_lvl),
    .valid (isr_any)
  );

  assign req_valid = pend_any && (!isr_any || (req_lvl < svc_lvl));

  ack_state_e       state;
  logic [LVL_W-1:0] ack_lvl;

  assign number_of_ack = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      ack_lvl <= SPURIOUS_LVL;
      int_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          int_out <= req_valid;
          if (inta_fall) begin
            state   <= ST_ACK1;
            ack_lvl <= req_valid ? req_lvl : SPURIOUS_LVL;
          end
        end
        ST_ACK1: begin
          int_out <= 1'b0;
          if (inta_fall) state <= ST_ACK2;
        end
        ST_ACK2: begin
          int_out <= 1'b0;
          if (inta_rise) state <= ST_IDLE;
        end
        default: begin
          int_out <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  logic             ack_take;
  logic             aeoi_clr;
  logic [N_IRQ-1:0] set_mask;
  logic [N_IRQ-1:0] clr_mask;
  logic [N_IRQ-1:0] irr_next;
  logic [N_IRQ-1:0] isr_next;

  assign ack_take = (state == ST_IDLE) && inta_fall && req_valid;
  assign aeoi_clr = (state == ST_ACK2) && inta_rise && aeoi;
  assign set_mask = ack_take ? lvl_mask(req_lvl) : '0;

  // A specific EOI overrides a simultaneous non-specific one.
  always_comb begin
    clr_mask = '0;
    if (eoi_spec) begin
      clr_mask = lvl_mask(eoi_level);
    end else if (eoi_nonspec && isr_any) begin
      clr_mask = lvl_mask(svc_lvl);
    end
    if (aeoi_clr) clr_mask = clr_mask | lvl_mask(ack_lvl);
  end

  // Setting wins over clearing; the acknowledge clear swallows a new edge.
  assign isr_next = (isr & ~clr_mask) | set_mask;
  assign irr_next = ltim ? (ir & ~set_mask) : ((irr | ir_rise) & ~set_mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_d   <= '0;
      inta_d <= 1'b1;
      irr    <= '0;
      isr    <= '0;
    end else begin
      ir_d   <= ir;
      inta_d <= inta_n;
      irr    <= irr_next;
      isr    <= isr_next;
    end
  end

endmodule
